// File: rtl/weight_fetch_pkg.sv
// Shared types and constants for the weight fetch engine.
// Holds the FSM state encoding and the output FIFO geometry.
package weight_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/weight_fetch_if.sv
// Valid/ready output stream carrying signed weight words plus an end-of-job flag.
// Master drives valid/data/last, slave drives ready.
interface weight_fetch_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH-1:0] m_data;
  logic                         m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Small output FIFO (FIFO_DEPTH entries); head is shown combinationally from storage.
// Caller guarantees no push when full and no pop when empty.
module fetch_fifo
  import weight_fetch_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_dat,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head_dat,
  output logic                  o_vld,
  output logic [FIFO_CNT_W-1:0] o_cnt
);

  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_wr;
  logic [FIFO_PTR_W-1:0] r_rd;
  logic [FIFO_CNT_W-1:0] r_cnt;

  // Storage is cleared on reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_push_dat;
        r_wr        <= FIFO_PTR_W'(r_wr + 1'b1);
      end
      if (i_pop) r_rd <= FIFO_PTR_W'(r_rd + 1'b1);
      r_cnt <= r_cnt + FIFO_CNT_W'(i_push) - FIFO_CNT_W'(i_pop);
    end
  end

  assign o_head_dat = r_mem[r_rd];
  assign o_vld      = (r_cnt != '0);
  assign o_cnt      = r_cnt;

endmodule

// File: rtl/weight_fetch.sv
// Streams a run of words from a 1-cycle synchronous ROM into a valid/ready output via a 4-entry FIFO.
// Optional WEIGHT_FETCH_STRIDE_EN adds a stride input; otherwise addresses step by one.
module weight_fetch
  import weight_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH:0]          length,
`ifdef WEIGHT_FETCH_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]        stride,
`endif
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic signed [DATA_WIDTH-1:0] rom_data,
  output logic                         busy,
  output logic                         done,
  weight_fetch_if.master               m_if
);

  localparam int OCC_W = FIFO_CNT_W + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   w_stride;
  logic [ADDR_WIDTH:0]     r_remain;
  logic [1:0]              r_ifl;
  logic [1:0]              r_ifl_last;
  logic                    r_done;
  logic                    w_issue;
  logic                    w_issue_last;
  logic                    w_zero_start;
  logic                    w_room;
  logic                    w_pop;
  logic                    w_last_hs;
  logic [OCC_W-1:0]        w_occ;
  logic [DATA_WIDTH:0]     w_head;
  logic                    w_fifo_vld;
  logic [FIFO_CNT_W-1:0]   w_cnt;

`ifdef WEIGHT_FETCH_STRIDE_EN
  logic [ADDR_WIDTH-1:0] r_stride;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_stride <= '0;
    else if (r_state == IDLE && w_issue) r_stride <= stride;
  end

  assign w_stride = r_stride;
`else
  assign w_stride = ADDR_WIDTH'(1);
`endif

  assign w_pop     = w_fifo_vld & m_if.m_ready;
  assign w_last_hs = w_pop & w_head[DATA_WIDTH];

  // Committed slots = queued words + words still in the ROM pipe; a pop this cycle frees one.
  assign w_occ  = OCC_W'(w_cnt) + OCC_W'(r_ifl[0]) + OCC_W'(r_ifl[1]) - OCC_W'(w_pop);
  assign w_room = (w_occ < OCC_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // The first address goes out on the start edge so data reaches the FIFO two edges later.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_zero_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_zero_start = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_issue_last = (length == (ADDR_WIDTH+1)'(1));
            w_state_nxt  = w_issue_last ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (w_room) begin
          w_issue      = 1'b1;
          w_issue_last = (r_remain == (ADDR_WIDTH+1)'(1));
          if (w_issue_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_remain   <= '0;
      r_ifl      <= '0;
      r_ifl_last <= '0;
      r_done     <= 1'b0;
    end else begin
      if (w_issue) begin
        if (r_state == IDLE) begin
          r_addr   <= base_addr;
          r_remain <= length - (ADDR_WIDTH+1)'(1);
        end else begin
          r_addr   <= r_addr + w_stride;
          r_remain <= r_remain - (ADDR_WIDTH+1)'(1);
        end
      end
      r_ifl      <= {r_ifl[0], w_issue};
      r_ifl_last <= {r_ifl_last[0], w_issue_last};
      r_done     <= w_zero_start | w_last_hs;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_ifl[1]),
    .i_push_dat ({r_ifl_last[1], rom_data}),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_vld      (w_fifo_vld),
    .o_cnt      (w_cnt)
  );

  assign rom_addr     = r_addr;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign m_if.m_valid = w_fifo_vld;
  assign m_if.m_data  = w_head[DATA_WIDTH-1:0];
  assign m_if.m_last  = w_head[DATA_WIDTH] & w_fifo_vld;

endmodule

// File: tb/tb_weight_fetch.sv
// Bench for weight_fetch: ROM model, queue scoreboard fed from a job-level reference model,
// and a decoupled monitor checking beats, stall stability and done timing.
module tb_weight_fetch;

  localparam int DW = 8;
  localparam int AW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [AW:0]          length = '0;
  logic [AW-1:0]        stride_v = '0;
  logic [AW-1:0]        rom_addr;
  logic signed [DW-1:0] rom_data;
  logic                 busy;
  logic                 done;

  weight_fetch_if #(.DATA_WIDTH(DW)) m_if ();

  weight_fetch #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef WEIGHT_FETCH_STRIDE_EN
    .stride    (stride_v),
`endif
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .done      (done),
    .m_if      (m_if)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 l;
  } beat_t;

  beat_t exp_q[$];

  // Reference model: word i of a job comes from (base + i*stride) mod 2^AW.
  task automatic push_job(input int b, input int l, input int s);
    beat_t e;
    for (int i = 0; i < l; i++) begin
      e.d = mem[(b + i * s) % (1 << AW)];
      e.l = (i == l - 1);
      exp_q.push_back(e);
    end
  endtask

  // Ready pattern: 0 = always high, 1 = alternate with an 8-cycle stall window, 2 = random.
  int rdy_mode = 0;
  int stall_lo = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_if.m_ready = (cyc >= stall_lo && cyc < stall_lo + 8) ? 1'b0 : (cyc % 2 == 0);
      2:       m_if.m_ready = 1'($urandom_range(0, 1));
      default: m_if.m_ready = 1'b1;
    endcase
  end

  int                   last_cyc = -10;
  int                   zl_cyc = -10;
  int                   done_cnt = 0;
  int                   beats_seen = 0;
  logic                 prev_stall = 1'b0;
  logic signed [DW-1:0] prev_data = '0;
  logic                 prev_last = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    logic  exp_done;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_if.m_valid, 1);
        chk("stall_data", m_if.m_data, prev_data);
        chk("stall_last", m_if.m_last, prev_last);
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_data  = m_if.m_data;
      prev_last  = m_if.m_last;
      if (m_if.m_valid && m_if.m_ready) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_data", m_if.m_data, e.d);
          chk("beat_last", m_if.m_last, e.l);
          beats_seen++;
          if (e.l) last_cyc = cyc;
        end
      end
      exp_done = (cyc == last_cyc + 1) || (cyc == zl_cyc + 1);
      if (exp_done || done) chk("done_pulse", done, exp_done);
      if (done) done_cnt++;
    end
  end

  task automatic issue_start(input int b, input int l, input int s, input bit acc);
    @(negedge clk);
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    stride_v  = AW'(s);
    start     = 1'b1;
    if (acc && l == 0) zl_cyc = cyc;
    if (acc && l > 0) push_job(b, l, s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget && done_cnt <= d0; k++) @(negedge clk);
    chk("job_done_seen", done_cnt > d0, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_job(input int b, input int l, input int s);
    int d0;
    d0 = done_cnt;
    issue_start(b, l, s, 1'b1);
    wait_done(d0, 2000);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int t0, d0, b0, s;
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);
    m_if.m_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_m_valid", m_if.m_valid, 0);
    chk("rst_m_last", m_if.m_last, 0);
    chk("rst_m_data", m_if.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: base 0x010, length 8, ready high -- latency, throughput, last, busy
    d0 = done_cnt;
    @(negedge clk);
    base_addr = AW'(16); length = (AW+1)'(8); stride_v = AW'(1); start = 1'b1;
    t0 = cyc;
    push_job(16, 8, 1);
    chk("t1_valid_at_start", m_if.m_valid, 0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      chk("t1_valid_timing", m_if.m_valid, (k >= 3 && k <= 10));
      chk("t1_last_timing", m_if.m_last, (k == 10));
      chk("t1_busy", busy, (k <= 10));
    end
    chk("t1_elapsed", cyc - t0, 11);
    wait_done(d0, 50);

    // Address wrap at the top of the ROM
    run_job(1022, 4, 1);

    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);

    // Alternating ready plus an 8-cycle stall
    rdy_mode = 1;
    stall_lo = cyc + 12;
    run_job(int'($urandom_range(0, 1023)), 16, 1);
    rdy_mode = 0;

    // Zero-length job: no beats, done next cycle, busy never rises
    d0 = done_cnt;
    issue_start(int'($urandom_range(0, 1023)), 0, 1, 1'b1);
    chk("zero_busy", busy, 0);
    chk("zero_done", done, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("zero_no_valid", m_if.m_valid, 0);
    end
    chk("zero_done_count", done_cnt - d0, 1);

    // Start while busy is ignored
    d0 = done_cnt;
    issue_start(100, 6, 1, 1'b1);
    chk("busy_after_start", busy, 1);
    @(negedge clk);
    issue_start(600, 5, 1, 1'b0);
    wait_done(d0, 200);
    for (int k = 0; k < 8; k++) @(negedge clk);
    chk("ignored_no_extra", m_if.m_valid, 0);
    chk("ignored_done_count", done_cnt - d0, 1);

    // Reset in the middle of a 10-word job
    d0 = done_cnt;
    b0 = beats_seen;
    issue_start(int'($urandom_range(0, 1023)), 10, 1, 1'b1);
    for (int k = 0; k < 200 && beats_seen < b0 + 3; k++) @(negedge clk);
    chk("abort_beats_seen", beats_seen >= b0 + 3, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_m_valid", m_if.m_valid, 0);
    chk("abort_m_last", m_if.m_last, 0);
    chk("abort_m_data", m_if.m_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_abort_idle", m_if.m_valid | done | busy, 0);
    end
    chk("abort_no_done", done_cnt - d0, 0);
    run_job(int'($urandom_range(0, 1023)), 2, 1);

    // Random jobs under random backpressure
    rdy_mode = 2;
    for (int j = 0; j < 8; j++) begin
`ifdef WEIGHT_FETCH_STRIDE_EN
      s = int'($urandom_range(0, 7));
`else
      s = 1;
`endif
      run_job(int'($urandom_range(0, 1023)), int'($urandom_range(1, 24)), s);
    end
    rdy_mode = 0;

`ifdef WEIGHT_FETCH_STRIDE_EN
    // Stride 4 from address 0, with a negative word at the head
    mem[0] = 8'h80;
    mem[4] = 8'h05;
    mem[8] = 8'h7F;
    d0 = done_cnt;
    issue_start(0, 3, 4, 1'b1);
    @(negedge clk);
    chk("stride_neg_word", m_if.m_data, -128);
    wait_done(d0, 50);
    run_job(int'($urandom_range(0, 1023)), 5, 0);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
